// File: rtl/bno_i2c_master.sv
// Byte-level I2C master for the BNO sensor bus; drives open-drain SCL/SDA output enables.
// Optional BNO_I2C_CLK_STRETCH_EN: quarter timer holds while a released SCL is held low by the slave.
`timescale 1ns/1ps
module bno_i2c_master #(
    parameter int QDIV   = 30,
    parameter int QDIV_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    input  logic       rd_nack,
    output logic       rsp_valid,
    output logic [7:0] rx_data,
    output logic       rsp_nack,
    output logic       rsp_err,
    output logic       bus_active,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;
    localparam logic [QDIV_W-1:0] Q_LAST = QDIV_W'(QDIV - 1);

    state_t            r_state;
    state_t            w_next;
    logic [QDIV_W-1:0] r_q;
    logic [1:0]        r_phase;
    logic [2:0]        r_bit;
    logic [1:0]        r_cmd;
    logic [7:0]        r_tx;
    logic [7:0]        r_rx;
    logic [7:0]        r_rx_data;
    logic              r_rd_nack;
    logic              r_ack_smp;
    logic              r_bus_active;
    logic              r_rsp_valid;
    logic              r_rsp_nack;
    logic              r_rsp_err;
    logic              r_sda_keep;
    logic              w_accept;
    logic              w_reject;
    logic              w_hold;
    logic              w_wrap;
    logic              w_last_q;
    logic              w_done;
    logic              w_scl_oe;
    logic              w_sda_oe;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_reject = w_accept && (cmd != CMD_START) && !r_bus_active;

`ifdef BNO_I2C_CLK_STRETCH_EN
    assign w_hold = (r_state != S_IDLE) && !w_scl_oe && !scl_in;
`else
    logic w_unused_scl;
    assign w_unused_scl = scl_in;
    assign w_hold       = 1'b0;
`endif

    assign w_wrap   = (r_q == Q_LAST) && !w_hold;
    assign w_last_q = w_wrap && (r_phase == 2'd3);
    assign w_done   = (r_state != S_IDLE) && (w_next == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_reject) begin
                    case (cmd)
                        CMD_START: w_next = S_START;
                        CMD_STOP:  w_next = S_STOP;
                        default:   w_next = S_BIT;
                    endcase
                end
            end
            S_START, S_ACK, S_STOP: if (w_last_q) w_next = S_IDLE;
            S_BIT:   if (w_last_q && (r_bit == 3'd7)) w_next = S_ACK;
            default: w_next = S_IDLE;
        endcase
    end

    // Between commands on an active bus SCL is parked low and SDA keeps its last level,
    // so the next command only ever moves SDA while SCL is already low.
    always_comb begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_scl_oe = r_bus_active;
                w_sda_oe = r_bus_active && r_sda_keep;
            end
            S_START: begin
                w_scl_oe = (r_phase == 2'd0) && r_bus_active;
                w_sda_oe = r_phase[1];
            end
            S_BIT: begin
                w_scl_oe = !r_phase[1];
                w_sda_oe = (r_cmd == CMD_WRITE) && !r_tx[7];
            end
            S_ACK: begin
                w_scl_oe = !r_phase[1];
                w_sda_oe = (r_cmd == CMD_READ) && !r_rd_nack;
            end
            S_STOP: begin
                w_scl_oe = (r_phase == 2'd0);
                w_sda_oe = !r_phase[1];
            end
            default: begin
                w_scl_oe = 1'b0;
                w_sda_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_phase <= 2'd0;
        end else if (r_state == S_IDLE) begin
            r_q     <= '0;
            r_phase <= 2'd0;
        end else if (!w_hold) begin
            if (r_q == Q_LAST) begin
                r_q     <= '0;
                r_phase <= r_phase + 2'd1;
            end else begin
                r_q <= r_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit        <= 3'd0;
            r_cmd        <= CMD_START;
            r_tx         <= 8'h00;
            r_rx         <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rd_nack    <= 1'b0;
            r_ack_smp    <= 1'b0;
            r_bus_active <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_nack   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_sda_keep   <= 1'b0;
        end else begin
            r_rsp_valid <= w_reject || w_done;
            r_rsp_err   <= w_reject;
            r_rsp_nack  <= w_done && (r_state == S_ACK) && (r_cmd == CMD_WRITE) && r_ack_smp;
            if (w_accept) begin
                r_cmd     <= cmd;
                r_tx      <= tx_data;
                r_rd_nack <= rd_nack;
                r_bit     <= 3'd0;
            end
            if ((r_state == S_BIT) && w_wrap && (r_phase == 2'd2)) r_rx <= {r_rx[6:0], sda_in};
            if ((r_state == S_ACK) && w_wrap && (r_phase == 2'd2)) r_ack_smp <= sda_in;
            if ((r_state == S_BIT) && w_last_q) begin
                r_tx  <= {r_tx[6:0], 1'b0};
                r_bit <= r_bit + 3'd1;
            end
            if (w_done && (r_state == S_ACK) && (r_cmd == CMD_READ)) r_rx_data <= r_rx;
            if (w_done && (r_state == S_START)) r_bus_active <= 1'b1;
            if (w_done && (r_state == S_STOP))  r_bus_active <= 1'b0;
            if (r_state != S_IDLE) r_sda_keep <= w_sda_oe;
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rx_data    = r_rx_data;
    assign rsp_nack   = r_rsp_nack;
    assign rsp_err    = r_rsp_err;
    assign bus_active = r_bus_active;
    assign scl_oe     = w_scl_oe;
    assign sda_oe     = w_sda_oe;
endmodule

// File: tb/tb_bno_i2c_master.sv
// Directed bench for bno_i2c_master: pull-up bus model plus a BNO slave at address 0x28.
`timescale 1ns/1ps
module tb_bno_i2c_master;
    localparam int QDIV = 4;
    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;
    localparam int LAT_SS = 4 * QDIV + 1;
    localparam int LAT_WR = 36 * QDIV + 1;
`ifdef BNO_I2C_CLK_STRETCH_EN
    localparam int STR_EXTRA = 20;
`else
    localparam int STR_EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       rd_nack = 1'b0;
    logic       rsp_valid;
    logic [7:0] rx_data;
    logic       rsp_nack;
    logic       rsp_err;
    logic       bus_active;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bno_i2c_master #(.QDIV(QDIV), .QDIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .tx_data(tx_data), .rd_nack(rd_nack),
        .rsp_valid(rsp_valid), .rx_data(rx_data), .rsp_nack(rsp_nack), .rsp_err(rsp_err),
        .bus_active(bus_active), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_in(scl_in), .sda_in(sda_in)
    );

    // Open-drain bus: a line is high unless the master or the slave pulls it
    localparam logic [6:0] SLV_ADDR    = 7'h28;
    localparam logic [7:0] SLV_RD_BYTE = 8'hA0;
    typedef enum logic [1:0] {M_IDLE, M_ADDR, M_WR, M_RD} smode_t;

    logic   scl_line;
    logic   sda_line;
    logic   s_scl_pull = 1'b0;
    logic   s_sda_pull = 1'b0;
    logic   s_pscl = 1'b1;
    logic   s_psda = 1'b1;
    logic   s_mack = 1'b0;
    logic   s_str_done = 1'b0;
    logic   stretch_arm = 1'b0;
    logic   slv_clr = 1'b0;
    logic [7:0] s_sr = 8'h00;
    logic [7:0] s_txsh = 8'h00;
    smode_t s_mode = M_IDLE;
    int     s_cnt = 0;
    int     s_str = 0;

    assign scl_line = !(scl_oe || s_scl_pull);
    assign sda_line = !(sda_oe || s_sda_pull);
    assign scl_in   = scl_line;
    assign sda_in   = sda_line;

    always @(negedge clk) begin
        s_pscl <= scl_line;
        s_psda <= sda_line;
        if (slv_clr) begin
            s_mode     <= M_IDLE;
            s_cnt      <= 0;
            s_sda_pull <= 1'b0;
            s_scl_pull <= 1'b0;
            s_str      <= 0;
        end else begin
            if (s_str != 0) begin
                s_str <= s_str - 1;
                if (s_str == 1) s_scl_pull <= 1'b0;
            end
            if (s_pscl && scl_line && s_psda && !sda_line) begin
                s_mode     <= M_ADDR;
                s_cnt      <= 0;
                s_sda_pull <= 1'b0;
            end else if (s_pscl && scl_line && !s_psda && sda_line) begin
                s_mode     <= M_IDLE;
                s_sda_pull <= 1'b0;
            end else if (!s_pscl && scl_line) begin
                if (s_cnt < 8) s_sr <= {s_sr[6:0], sda_line};
                else           s_mack <= sda_line;
                s_cnt <= s_cnt + 1;
            end else if (s_pscl && !scl_line) begin
                // Stretch: hold SCL from the start of address bit 3 until 20 cycles past the master release
                if ((s_cnt == 3) && (s_mode == M_ADDR) && stretch_arm && !s_str_done) begin
                    s_scl_pull <= 1'b1;
                    s_str      <= 2 * QDIV + 20;
                    s_str_done <= 1'b1;
                end
                if (s_cnt == 8) begin
                    s_sda_pull <= ((s_mode == M_ADDR) && (s_sr[7:1] == SLV_ADDR)) || (s_mode == M_WR);
                end else if (s_cnt >= 9) begin
                    s_cnt <= 0;
                    if ((s_mode == M_ADDR) && (s_sr[7:1] == SLV_ADDR) && s_sr[0]) begin
                        s_mode     <= M_RD;
                        s_sda_pull <= !SLV_RD_BYTE[7];
                        s_txsh     <= SLV_RD_BYTE << 1;
                    end else if ((s_mode == M_ADDR) && (s_sr[7:1] == SLV_ADDR)) begin
                        s_mode     <= M_WR;
                        s_sda_pull <= 1'b0;
                    end else begin
                        s_mode     <= M_IDLE;
                        s_sda_pull <= 1'b0;
                    end
                end else if (s_mode == M_RD) begin
                    s_sda_pull <= !s_txsh[7];
                    s_txsh     <= s_txsh << 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command; latency counts the accept edge as 1.
    task automatic send(input logic [1:0] c, input logic [7:0] d, input logic nk,
                        output int lat, output logic err, output logic nck, output logic pads);
        @(negedge clk);
        cmd = c; tx_data = d; rd_nack = nk; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat  = 1;
        pads = scl_oe | sda_oe;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            pads = pads | scl_oe | sda_oe;
        end
        err = rsp_err;
        nck = rsp_nack;
        @(posedge clk); #1;
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic err;
        logic nck;
        logic pads;

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_bus_active", 32'(bus_active), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);

        send(C_READ, 8'h00, 1'b0, lat, err, nck, pads);
        check("rej_latency", 32'(lat), 32'd1);
        check("rej_err", 32'(err), 32'd1);
        check("rej_pads", 32'(pads), 32'd0);

        send(C_START, 8'h00, 1'b0, lat, err, nck, pads);
        check("start_latency", 32'(lat), 32'(LAT_SS));
        check("start_err", 32'(err), 32'd0);
        check("start_bus_active", 32'(bus_active), 32'd1);

        send(C_WRITE, 8'h50, 1'b0, lat, err, nck, pads);
        check("wr50_latency", 32'(lat), 32'(LAT_WR));
        check("wr50_nack", 32'(nck), 32'd0);
        check("wr50_bus_bits", 32'(s_sr), 32'h50);

        send(C_START, 8'h00, 1'b0, lat, err, nck, pads);
        check("rstart_latency", 32'(lat), 32'(LAT_SS));
        check("rstart_bus_active", 32'(bus_active), 32'd1);

        send(C_WRITE, 8'h51, 1'b0, lat, err, nck, pads);
        check("wr51_nack", 32'(nck), 32'd0);

        send(C_READ, 8'h00, 1'b1, lat, err, nck, pads);
        check("rd_latency", 32'(lat), 32'(LAT_WR));
        check("rd_rx_data", 32'(rx_data), 32'hA0);
        check("rd_nack_rsp", 32'(nck), 32'd0);
        check("rd_master_ack_sda", 32'(s_mack), 32'd1);

        send(C_STOP, 8'h00, 1'b0, lat, err, nck, pads);
        check("stop_latency", 32'(lat), 32'(LAT_SS));
        check("stop_bus_active", 32'(bus_active), 32'd0);

        send(C_START, 8'h00, 1'b0, lat, err, nck, pads);
        send(C_WRITE, 8'h52, 1'b0, lat, err, nck, pads);
        check("wr52_nack", 32'(nck), 32'd1);
        send(C_STOP, 8'h00, 1'b0, lat, err, nck, pads);
        check("stop2_err", 32'(err), 32'd0);
        check("stop2_bus_active", 32'(bus_active), 32'd0);
        check("rx_data_held", 32'(rx_data), 32'hA0);

        stretch_arm = 1'b1;
        send(C_START, 8'h00, 1'b0, lat, err, nck, pads);
        send(C_WRITE, 8'h50, 1'b0, lat, err, nck, pads);
        check("stretch_latency", 32'(lat), 32'(LAT_WR + STR_EXTRA));
`ifdef BNO_I2C_CLK_STRETCH_EN
        check("stretch_nack", 32'(nck), 32'd0);
`endif
        send(C_STOP, 8'h00, 1'b0, lat, err, nck, pads);
        check("stretch_stop_bus_active", 32'(bus_active), 32'd0);

        @(negedge clk) slv_clr = 1'b1;
        @(negedge clk) slv_clr = 1'b0;
        send(C_START, 8'h00, 1'b0, lat, err, nck, pads);
        @(negedge clk);
        cmd = C_WRITE; tx_data = 8'h50; rd_nack = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        check("midwr_scl_oe", 32'(scl_oe), 32'd1);
        check("midwr_sda_oe", 32'(sda_oe), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_scl_oe", 32'(scl_oe), 32'd0);
        check("arst_sda_oe", 32'(sda_oe), 32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("arst_bus_active", 32'(bus_active), 32'd0);
        check("arst_rx_data", 32'(rx_data), 32'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
